// File: rtl/bratcr_ctrl_pkg.sv
// Shared sizing, slot record and FSM encoding for the branch RAT copy
// register (BRATCR) checkpoint controller.
package bratcr_ctrl_pkg;

   localparam int ISSUE_WIDTH_MAX     = 2;
   localparam int ROB_MAX_RETIRE      = 2;
   localparam int ROB_SIZE_CLOG       = 5;
   localparam int BRATCR_NUM_ETY      = 4;
   localparam int BRATCR_NUM_ETY_CLOG = 2;

   typedef logic [BRATCR_NUM_ETY_CLOG-1:0] slot_idx_t;
   typedef logic [BRATCR_NUM_ETY_CLOG:0]   slot_cnt_t;
   typedef logic [ROB_SIZE_CLOG-1:0]       robid_t;

   typedef struct packed {
      logic   valid;
      robid_t robid;
   } bratcr_ctl_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RESTORE = 2'd1,
      RESUME  = 2'd2
   } bratcr_state_t;

endpackage

// File: rtl/bratcr_alloc.sv
// Lane-to-slot assignment for newly issued branches plus the all-or-nothing
// full check against the registered occupancy.
module bratcr_alloc
   import bratcr_ctrl_pkg::*;
(
   input  logic [ISSUE_WIDTH_MAX-1:0]                          branch_val_id,
   input  slot_idx_t                                           tail,
   input  slot_cnt_t                                           count,
   input  logic                                                alloc_allow,
   output logic [ISSUE_WIDTH_MAX-1:0]                          wr_en,
   output logic [ISSUE_WIDTH_MAX-1:0][BRATCR_NUM_ETY_CLOG-1:0] wr_idx,
   output slot_cnt_t                                           n_req,
   output logic                                                full
);

   slot_cnt_t below;
   logic [BRATCR_NUM_ETY_CLOG+1:0] demand;

   // Each lane's slot is offset from tail by the number of valid lanes below it.
   always_comb begin
      below = '0;
      for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
         wr_idx[k] = tail + below[BRATCR_NUM_ETY_CLOG-1:0];
         below     = below + slot_cnt_t'(branch_val_id[k]);
      end
      n_req = below;
   end

   assign demand = {1'b0, count} + {1'b0, n_req};
   assign full   = demand > (BRATCR_NUM_ETY_CLOG+2)'(BRATCR_NUM_ETY);
   assign wr_en  = (alloc_allow && !full) ? branch_val_id : '0;

endmodule

// File: rtl/bratcr_ctrl.sv
// Circular-queue allocator for RAT checkpoints: in-order allocate at tail,
// oldest-first free at head, and mispredict truncation with a restore FSM.
module bratcr_ctrl
   import bratcr_ctrl_pkg::*;
(
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [ISSUE_WIDTH_MAX-1:0]                          branch_val_id,
   input  logic [ROB_SIZE_CLOG-1:0]                            rob_is_ptr,
   input  logic [ROB_MAX_RETIRE-1:0]                           branch_ret,
   input  logic                                                mispredict_val,
   input  logic [ROB_SIZE_CLOG-1:0]                            mispredict_robid,
   output logic [ISSUE_WIDTH_MAX-1:0]                          ckpt_wr_en,
   output logic [ISSUE_WIDTH_MAX-1:0][BRATCR_NUM_ETY_CLOG-1:0] ckpt_wr_idx,
   output logic                                                restore_en,
   output logic [BRATCR_NUM_ETY_CLOG-1:0]                      restore_idx,
   output logic                                                stall_id,
   output logic [BRATCR_NUM_ETY_CLOG:0]                        ckpt_count,
   output logic                                                mispredict_err
);

   bratcr_state_t state;
   slot_idx_t     head;
   slot_idx_t     tail;
   slot_cnt_t     count;
   bratcr_ctl_t   slots     [BRATCR_NUM_ETY];
   bratcr_ctl_t   slots_nxt [BRATCR_NUM_ETY];

   slot_cnt_t n_req;
   slot_cnt_t n_free;
   slot_cnt_t n_alloc;
   logic      full;
   logic      in_run;
   logic      mp_take;
   logic      mp_hit;
   slot_idx_t mp_slot;
   slot_idx_t mp_dist;
   slot_idx_t age;

   assign in_run  = (state == RUN);
   assign mp_take = in_run && mispredict_val;

   bratcr_alloc u_alloc (
      .branch_val_id (branch_val_id),
      .tail          (tail),
      .count         (count),
      .alloc_allow   (in_run && !mispredict_val),
      .wr_en         (ckpt_wr_en),
      .wr_idx        (ckpt_wr_idx),
      .n_req         (n_req),
      .full          (full)
   );

   assign n_alloc    = (|ckpt_wr_en) ? n_req : '0;
   assign stall_id   = !in_run || full;
   assign ckpt_count = count;
   assign mp_dist    = mp_slot - head;

   always_comb begin
      n_free = '0;
      for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
         n_free = n_free + slot_cnt_t'(branch_ret[r]);
      end
   end

   always_comb begin
      mp_hit  = 1'b0;
      mp_slot = '0;
      for (int i = 0; i < BRATCR_NUM_ETY; i++) begin
         if (slots[i].valid && (slots[i].robid == mispredict_robid)) begin
            mp_hit  = 1'b1;
            mp_slot = slot_idx_t'(i);
         end
      end
   end

   // Frees come first, then fresh allocations, then mispredict truncation of
   // everything at or younger than the matching slot (age measured from head).
   always_comb begin
      age = '0;
      for (int i = 0; i < BRATCR_NUM_ETY; i++) begin
         slots_nxt[i] = slots[i];
      end
      for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
         if (slot_cnt_t'(r) < n_free) begin
            slots_nxt[head + slot_idx_t'(r)].valid = 1'b0;
         end
      end
      for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
         if (ckpt_wr_en[k]) begin
            slots_nxt[ckpt_wr_idx[k]].valid = 1'b1;
            slots_nxt[ckpt_wr_idx[k]].robid = rob_is_ptr + robid_t'(k);
         end
      end
      if (mp_take && mp_hit) begin
         for (int i = 0; i < BRATCR_NUM_ETY; i++) begin
            age = slot_idx_t'(i) - head;
            if (age >= mp_dist) begin
               slots_nxt[i].valid = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= RUN;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         restore_en     <= 1'b0;
         restore_idx    <= '0;
         mispredict_err <= 1'b0;
         for (int i = 0; i < BRATCR_NUM_ETY; i++) begin
            slots[i] <= '0;
         end
      end else begin
         slots          <= slots_nxt;
         head           <= head + n_free[BRATCR_NUM_ETY_CLOG-1:0];
         restore_en     <= 1'b0;
         mispredict_err <= 1'b0;
         if (mp_take && mp_hit) begin
            tail  <= mp_slot;
            count <= slot_cnt_t'(mp_dist) - n_free;
         end else begin
            tail  <= tail + n_alloc[BRATCR_NUM_ETY_CLOG-1:0];
            count <= count + n_alloc - n_free;
         end
         case (state)
            RUN: begin
               if (mp_take && mp_hit) begin
                  state       <= RESTORE;
                  restore_en  <= 1'b1;
                  restore_idx <= mp_slot;
               end else if (mp_take) begin
                  mispredict_err <= 1'b1;
               end
            end
            RESTORE: state <= RESUME;
            RESUME:  state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Retiring more branches than are checkpointed means the ROB and this
   // controller have lost sync.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (n_free <= count);
      end
   end

endmodule

// File: tb/tb_bratcr_ctrl.sv
// Vector-table bench for bratcr_ctrl: combinational outputs checked in-cycle,
// registered outputs predicted into a scoreboard and compared after the edge.
module tb_bratcr_ctrl;
   import bratcr_ctrl_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      branch_val_id;
   logic [4:0]      rob_is_ptr;
   logic [1:0]      branch_ret;
   logic            mispredict_val;
   logic [4:0]      mispredict_robid;
   logic [1:0]      ckpt_wr_en;
   logic [1:0][1:0] ckpt_wr_idx;
   logic            restore_en;
   logic [1:0]      restore_idx;
   logic            stall_id;
   logic [2:0]      ckpt_count;
   logic            mispredict_err;

   typedef struct {
      logic       rst;
      logic [1:0] bv;
      logic [4:0] ptr;
      logic [1:0] br;
      logic       mv;
      logic [4:0] mrob;
      logic [1:0] wr_en;
      logic [3:0] wr_idx;
      logic       stall;
      logic [2:0] count;
      logic       ren;
      logic [1:0] ridx;
      logic       err;
   } vec_t;

   typedef struct {
      logic [2:0] count;
      logic       ren;
      logic [1:0] ridx;
      logic       err;
      int         tag;
   } exp_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];
   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;

   bratcr_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .branch_val_id    (branch_val_id),
      .rob_is_ptr       (rob_is_ptr),
      .branch_ret       (branch_ret),
      .mispredict_val   (mispredict_val),
      .mispredict_robid (mispredict_robid),
      .ckpt_wr_en       (ckpt_wr_en),
      .ckpt_wr_idx      (ckpt_wr_idx),
      .restore_en       (restore_en),
      .restore_idx      (restore_idx),
      .stall_id         (stall_id),
      .ckpt_count       (ckpt_count),
      .mispredict_err   (mispredict_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      exp_t e;
      rst              = v.rst;
      branch_val_id    = v.bv;
      rob_is_ptr       = v.ptr;
      branch_ret       = v.br;
      mispredict_val   = v.mv;
      mispredict_robid = v.mrob;
      #1;
      check($sformatf("v%0d wr_en", idx), int'(ckpt_wr_en), int'(v.wr_en));
      check($sformatf("v%0d wr_idx", idx), int'(ckpt_wr_idx), int'(v.wr_idx));
      check($sformatf("v%0d stall", idx), int'(stall_id), int'(v.stall));
      e.count = v.count;
      e.ren   = v.ren;
      e.ridx  = v.ridx;
      e.err   = v.err;
      e.tag   = idx;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check($sformatf("v%0d count", e.tag), int'(ckpt_count), int'(e.count));
         check($sformatf("v%0d restore_en", e.tag), int'(restore_en), int'(e.ren));
         check($sformatf("v%0d restore_idx", e.tag), int'(restore_idx), int'(e.ridx));
         check($sformatf("v%0d mispredict_err", e.tag), int'(mispredict_err), int'(e.err));
      end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //           rst  bv     ptr  br     mv   mrob  wr_en  wr_idx   st   cnt ren ridx   err
      vecs[0]  = '{0, 2'b11,  5, 2'b00, 0,  0, 2'b11, 4'b0100, 0, 3'd2, 0, 2'd0, 0};
      vecs[1]  = '{0, 2'b00,  0, 2'b00, 1,  6, 2'b00, 4'b1010, 0, 3'd1, 1, 2'd1, 0};
      vecs[2]  = '{0, 2'b00,  0, 2'b00, 0,  0, 2'b00, 4'b0101, 1, 3'd1, 0, 2'd1, 0};
      vecs[3]  = '{0, 2'b11,  3, 2'b00, 0,  0, 2'b00, 4'b1001, 1, 3'd1, 0, 2'd1, 0};
      vecs[4]  = '{0, 2'b00,  0, 2'b01, 0,  0, 2'b00, 4'b0101, 0, 3'd0, 0, 2'd1, 0};
      vecs[5]  = '{0, 2'b10,  9, 2'b00, 0,  0, 2'b10, 4'b0101, 0, 3'd1, 0, 2'd1, 0};
      vecs[6]  = '{0, 2'b00,  0, 2'b00, 1, 20, 2'b00, 4'b1010, 0, 3'd1, 0, 2'd1, 1};
      vecs[7]  = '{0, 2'b00,  0, 2'b00, 0,  0, 2'b00, 4'b1010, 0, 3'd1, 0, 2'd1, 0};
      vecs[8]  = '{0, 2'b11, 11, 2'b00, 0,  0, 2'b11, 4'b1110, 0, 3'd3, 0, 2'd1, 0};
      vecs[9]  = '{0, 2'b11, 13, 2'b00, 0,  0, 2'b00, 4'b0100, 1, 3'd3, 0, 2'd1, 0};
      vecs[10] = '{0, 2'b11, 13, 2'b01, 0,  0, 2'b00, 4'b0100, 1, 3'd2, 0, 2'd1, 0};
      vecs[11] = '{0, 2'b01, 14, 2'b00, 0,  0, 2'b01, 4'b0100, 0, 3'd3, 0, 2'd1, 0};
      vecs[12] = '{0, 2'b00,  0, 2'b00, 1, 12, 2'b00, 4'b0101, 0, 3'd1, 1, 2'd3, 0};
      vecs[13] = '{0, 2'b00,  0, 2'b00, 1, 11, 2'b00, 4'b1111, 1, 3'd1, 0, 2'd3, 0};
      vecs[14] = '{0, 2'b00,  0, 2'b00, 0,  0, 2'b00, 4'b1111, 1, 3'd1, 0, 2'd3, 0};
      vecs[15] = '{0, 2'b11, 20, 2'b00, 0,  0, 2'b11, 4'b0011, 0, 3'd3, 0, 2'd3, 0};
      vecs[16] = '{0, 2'b00,  0, 2'b01, 1, 21, 2'b00, 4'b0101, 0, 3'd1, 1, 2'd0, 0};
      vecs[17] = '{1, 2'b00,  0, 2'b00, 0,  0, 2'b00, 4'b0000, 1, 3'd0, 0, 2'd0, 0};
      vecs[18] = '{0, 2'b10,  9, 2'b00, 0,  0, 2'b10, 4'b0000, 0, 3'd1, 0, 2'd0, 0};
      vecs[19] = '{0, 2'b00,  0, 2'b00, 1, 10, 2'b00, 4'b0101, 0, 3'd0, 1, 2'd0, 0};
      vecs[20] = '{0, 2'b00,  0, 2'b00, 0,  0, 2'b00, 4'b0000, 1, 3'd0, 0, 2'd0, 0};

      rst              = 1'b1;
      branch_val_id    = '0;
      rob_is_ptr       = '0;
      branch_ret       = '0;
      mispredict_val   = 1'b0;
      mispredict_robid = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset count", int'(ckpt_count), 0);
      check("reset restore_en", int'(restore_en), 0);
      check("reset restore_idx", int'(restore_idx), 0);
      check("reset mispredict_err", int'(mispredict_err), 0);
      check("reset stall", int'(stall_id), 0);
      check("reset wr_en", int'(ckpt_wr_en), 0);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(i, vecs[i]);
         @(posedge clk);
         #1;
         checkOutput();
      end

      // Restore pulse already cleared above; a second idle cycle must return to RUN.
      rst = 1'b0;
      branch_val_id = 2'b00;
      mispredict_val = 1'b0;
      @(posedge clk);
      #1;
      check("post-resume stall", int'(stall_id), 0);
      check("leftover scoreboard", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
